// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
// Holds the handshake state encoding, the NOP instruction word and the default payload width.
package rv_pipe_pkg;

    localparam int RV_DATA_W = 160;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // A stage presents data downstream whenever it holds at least one payload.
    function automatic logic rv_holds_payload(input pipe_state_e s);
        return (s != EMPTY);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Used by pipe_stage_reg to count back-pressured cycles.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and a back-pressure cycle counter.
// Define RV_PIPE_SKID_EN for the two-entry skid version with a registered in_ready.
//
// state | meaning
// EMPTY | no payload held, out_valid low
// FULL  | main register holds the payload presented downstream
// SKID  | main and skid registers both hold payloads, upstream stalled
module pipe_stage_reg
    import rv_pipe_pkg::*;
#(
    parameter int                DATA_W  = RV_DATA_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

`ifdef RV_PIPE_SKID_EN

    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_q;
    logic              in_ready_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the downstream side can move.
                    if (out_xfer) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = rv_holds_payload(state_d);
        in_ready_d  = (state_d != SKID);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_q     <= RST_VAL;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;

`else

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    // in_ready is low while full and stalled, so input-only cannot occur.
                    if (in_xfer) begin
                        main_d = in_data;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = rv_holds_payload(state_d);
    end

    assign in_ready = !out_valid_q || out_ready;

`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            main_q      <= RST_VAL;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            main_q      <= main_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Flush leaves the statistic alone; only reset clears it.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (out_valid_q && !out_ready),
        .clear (1'b0),
        .count (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 160, SHALL set the payload width in bits (PC, instruction, controls, operands).
REQ-002 Parameter RST_VAL, default all-zero DATA_W, SHALL set the payload value loaded on reset and flush (the bubble encoding).
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Port clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 Port rstn  in  1  reset, asynchronous, active-low.
REQ-006 Port flush  in  1  synchronous pipeline flush (branch/jump redirect).
REQ-007 Port in_valid  in  1  upstream payload valid.
REQ-008 Port in_ready  out  1  stage accepts payload this cycle.
REQ-009 Port in_data  in  DATA_W  upstream payload.
REQ-010 Port out_valid  out  1  payload presented downstream.
REQ-011 Port out_ready  in  1  downstream accepts payload.
REQ-012 Port out_data  out  DATA_W  registered payload.
REQ-013 Port stall_cnt  out  CNT_W  count of back-pressured cycles.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 State machine SHALL have states EMPTY, FULL, SKID (SKID only per REQ-028); out_valid SHALL be 1 exactly in FULL and SKID.
REQ-016 EMPTY: on input transfer go FULL, main register <= in_data, else stay.
REQ-017 FULL: input and output transfer both -> stay FULL, main <= in_data; output only -> EMPTY; input only -> SKID, skid register <= in_data; neither -> stay.
REQ-018 SKID: output transfer -> FULL, main <= skid register; otherwise stay, holding both registers.
REQ-019 out_data SHALL always drive the main register; latency in_data -> out_data SHALL be one cycle when the stage is EMPTY or draining.
REQ-020 Payload SHALL be delivered in order, none dropped or duplicated, absent flush.
REQ-021 flush SHALL have priority over all transfers: next state EMPTY, main and skid registers <= RST_VAL, any same-cycle in_data discarded, out_valid 0 next cycle.
REQ-022 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturating at 2^CNT_W-1; flush SHALL NOT clear it.

Reset
REQ-023 While rstn low: state EMPTY, out_valid 0, out_data RST_VAL, skid register RST_VAL, stall_cnt 0.
REQ-024 In skid mode in_ready SHALL be 1 during reset; assertion of rstn mid-transfer SHALL discard all held payload.
REQ-025 Reset deassertion SHALL take effect on the first rising clk edge after rstn goes high; no transfer is recognised before it.

Configuration
REQ-026 Macro RV_PIPE_SKID_EN SHALL select the skid-buffer implementation.
REQ-027 Without RV_PIPE_SKID_EN: states EMPTY/FULL only, no skid register, in_ready = !out_valid || out_ready (combinational from out_ready).
REQ-028 With RV_PIPE_SKID_EN: SKID state and skid register present, in_ready SHALL be registered, equal to (state != SKID), giving full throughput with no combinational out_ready -> in_ready path.

Structure
REQ-029 Shared package rv_pipe_pkg SHALL hold the state enum (EMPTY, FULL, SKID), constant RV_NOP = 32'h0000_0013 and the default DATA_W.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter width; inputs inc, clear; output count).
REQ-031 The stage SHALL contain no other sub-modules; DEtoALU and later stage registers SHALL instantiate pipe_stage_reg with packed payloads.

Verification
REQ-032 Reset: rstn low 3 cycles with in_valid=1 -> out_valid 0, out_data RST_VAL, stall_cnt 0, in_ready 1.
REQ-033 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, no gaps.
REQ-034 Back-pressure (skid on): stream 10,11,12, out_ready low 2 cycles after 10 appears -> SKID holds 11, in_ready 0, 12 held upstream; release -> 10,11,12 in order, stall_cnt = 2.
REQ-035 Flush: stage in SKID with 5 and 6, flush=1 with in_valid=1 data 7 -> next cycle out_valid 0, out_data RST_VAL, 7 not delivered; stall_cnt unchanged.
REQ-036 Saturation: CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-037 Skid off: repeat REQ-034 stimulus -> in_ready tracks out_ready same-cycle, outputs 10,11,12 in order, no SKID state reached.
